// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci XNOR LFSR with seed load, period
// measurement, output-bit statistics and lock-up protection.
module lfsr_gen #(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hD008,
   parameter logic [WIDTH-1:0] SEED  = 16'h0145,
   parameter int unsigned      CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sh_en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [CNT_W-1:0] ones,
   output logic [CNT_W-1:0] zeros,
   output logic             period_tick,
   output logic [CNT_W-1:0] period_len,
   output logic             lockup_err
);

   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_gen: WIDTH out of range 2..32");
   end

   if (SEED == {WIDTH{1'b1}}) begin : g_bad_seed
      $error("lfsr_gen: SEED must not be the all-ones lock-up state");
   end

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [CNT_W-1:0] step_q, step_d;
   logic [CNT_W-1:0] ones_q, ones_d;
   logic [CNT_W-1:0] zeros_q, zeros_d;
   logic [CNT_W-1:0] plen_q, plen_d;
   logic             tick_q, tick_d;
   logic             lerr_q, lerr_d;
   logic             fb;
   logic [WIDTH-1:0] nxt;

   // Next state: load beats step beats hold; pulses default low.
   always_comb begin
      q_d     = q_q;
      start_d = start_q;
      step_d  = step_q;
      ones_d  = ones_q;
      zeros_d = zeros_q;
      plen_d  = plen_q;
      tick_d  = 1'b0;
      lerr_d  = 1'b0;
      fb      = ~^(q_q & TAPS);
      nxt     = {q_q[WIDTH-2:0], fb};
      if (load) begin
         step_d  = '0;
         ones_d  = '0;
         zeros_d = '0;
         if (&load_val) begin
            q_d     = SEED;
            start_d = SEED;
            lerr_d  = 1'b1;
         end else begin
            q_d     = load_val;
            start_d = load_val;
         end
      end else if (sh_en) begin
         q_d = nxt;
         if (q_q[WIDTH-1]) begin
            if (!(&ones_q)) ones_d = ones_q + ONE_C;
         end else begin
            if (!(&zeros_q)) zeros_d = zeros_q + ONE_C;
         end
         if (nxt == start_q) begin
            plen_d = (&step_q) ? step_q : step_q + ONE_C;
            step_d = '0;
            tick_d = 1'b1;
         end else if (!(&step_q)) begin
            step_d = step_q + ONE_C;
         end
      end
   end

   // State and output registers, async active-high reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q     <= SEED;
         start_q <= SEED;
         step_q  <= '0;
         ones_q  <= '0;
         zeros_q <= '0;
         plen_q  <= '0;
         tick_q  <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         q_q     <= q_d;
         start_q <= start_d;
         step_q  <= step_d;
         ones_q  <= ones_d;
         zeros_q <= zeros_d;
         plen_q  <= plen_d;
         tick_q  <= tick_d;
         lerr_q  <= lerr_d;
      end
   end

   assign q           = q_q;
   assign ones        = ones_q;
   assign zeros       = zeros_q;
   assign period_tick = tick_q;
   assign period_len  = plen_q;
   assign lockup_err  = lerr_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed vectors for lfsr_gen, checked by a
// cycle-stamped scoreboard drained at each falling edge.
module tb_lfsr_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        sh_en, load;
   logic [15:0] load_val;
   logic [15:0] q;
   logic [31:0] ones, zeros, period_len;
   logic        period_tick, lockup_err;

   logic        sh4, ld4;
   logic [3:0]  lv4, q4, ones4, zeros4, plen4;
   logic        tick4, lerr4;

   typedef struct {
      int unsigned cyc;
      int          sel;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          applied = 0;
   int          miscompares = 0;

   logic [15:0] first3 [3]  = '{16'h028B, 16'h0516, 16'h0A2D};
   logic [3:0]  seq4   [15] = '{4'h3, 4'h7, 4'hE, 4'hD, 4'hB,
                                4'h6, 4'hC, 4'h9, 4'h2, 4'h5,
                                4'hA, 4'h4, 4'h8, 4'h0, 4'h1};

   lfsr_gen u_dut (
      .clk         (clk),
      .reset       (reset),
      .sh_en       (sh_en),
      .load        (load),
      .load_val    (load_val),
      .q           (q),
      .ones        (ones),
      .zeros       (zeros),
      .period_tick (period_tick),
      .period_len  (period_len),
      .lockup_err  (lockup_err)
   );

   lfsr_gen #(
      .WIDTH (4),
      .TAPS  (4'b1100),
      .SEED  (4'h1),
      .CNT_W (4)
   ) u_dut4 (
      .clk         (clk),
      .reset       (reset),
      .sh_en       (sh4),
      .load        (ld4),
      .load_val    (lv4),
      .q           (q4),
      .ones        (ones4),
      .zeros       (zeros4),
      .period_tick (tick4),
      .period_len  (plen4),
      .lockup_err  (lerr4)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Count rising edges; expectations are stamped with this.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] probe(input int sel);
      case (sel)
         0:       return 32'(q);
         1:       return ones;
         2:       return zeros;
         3:       return 32'(period_tick);
         4:       return period_len;
         5:       return 32'(lockup_err);
         10:      return 32'(q4);
         11:      return 32'(ones4);
         12:      return 32'(zeros4);
         13:      return 32'(tick4);
         14:      return 32'(plen4);
         15:      return 32'(lerr4);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic push(input int sel, input logic [31:0] v,
                       input string n, input int unsigned at);
      exp_t e;
      e.cyc  = at;
      e.sel  = sel;
      e.exp  = v;
      e.name = n;
      sb.push_back(e);
   endtask

   // Expect after the coming rising edge.
   task automatic chk(input int sel, input logic [31:0] v,
                      input string n);
      push(sel, v, n, cyc + 1);
   endtask

   // Expect at the next falling edge, with no rising edge between.
   task automatic now(input int sel, input logic [31:0] v,
                      input string n);
      push(sel, v, n, cyc);
   endtask

   task automatic drv(input logic s, input logic l,
                      input logic [15:0] v, input logic s4);
      @(negedge clk);
      #1;
      sh_en    = s;
      load     = l;
      load_val = v;
      sh4      = s4;
      ld4      = 1'b0;
      lv4      = 4'h0;
   endtask

   // Monitor: pop and compare every expectation due this cycle.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         applied++;
         if (e.cyc != cyc) begin
            miscompares++;
            $display("FAIL %s: stale, due cycle %0d, now %0d",
                     e.name, e.cyc, cyc);
         end else if (probe(e.sel) !== e.exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     e.name, probe(e.sel), e.exp, cyc);
         end
      end
   end

   initial begin
      reset    = 1'b1;
      sh_en    = 1'b0;
      load     = 1'b0;
      load_val = 16'h0;
      sh4      = 1'b0;
      ld4      = 1'b0;
      lv4      = 4'h0;
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         drv(1'b0, 1'b0, 16'h0, 1'b0);
         chk(0, 32'h0145, "hold_q");
         chk(3, 32'd0, "hold_tick");
         chk(5, 32'd0, "hold_lerr");
         if (i == 9) begin
            chk(1, 32'd0, "hold_ones");
            chk(2, 32'd0, "hold_zeros");
            chk(4, 32'd0, "hold_plen");
            chk(10, 32'h1, "hold_q4");
         end
      end

      for (int i = 0; i < 3; i++) begin
         drv(1'b1, 1'b0, 16'h0, 1'b0);
         chk(0, 32'(first3[i]), "step_q");
         chk(3, 32'd0, "step_tick");
      end
      chk(1, 32'd0, "step3_ones");
      chk(2, 32'd3, "step3_zeros");

      for (int i = 3; i < 1000; i++) begin
         drv(1'b1, 1'b0, 16'h0, 1'b0);
         chk(3, 32'd0, "pre_tick");
      end

      @(posedge clk);
      #1;
      reset = 1'b1;
      sh_en = 1'b0;
      now(0, 32'h0145, "async_q");
      now(1, 32'd0, "async_ones");
      now(2, 32'd0, "async_zeros");
      now(3, 32'd0, "async_tick");
      now(4, 32'd0, "async_plen");
      @(negedge clk);
      #1 reset = 1'b0;

      for (int i = 1; i <= 65535; i++) begin
         drv(1'b1, 1'b0, 16'h0, 1'b0);
         chk(3, 32'(i == 65535), "period_tick");
         if (i == 65534) chk(4, 32'd0, "plen_before");
         if (i == 65535) begin
            chk(0, 32'h0145, "period_q");
            chk(4, 32'd65535, "period_len");
            chk(1, 32'd32767, "period_ones");
            chk(2, 32'd32768, "period_zeros");
         end
      end

      drv(1'b1, 1'b0, 16'h0, 1'b0);
      chk(3, 32'd0, "after_tick");
      chk(0, 32'h028B, "after_q");
      chk(1, 32'd32767, "after_ones");
      chk(2, 32'd32769, "after_zeros");
      chk(4, 32'd65535, "after_plen");

      repeat (2) begin
         drv(1'b0, 1'b0, 16'h0, 1'b0);
         chk(3, 32'd0, "hold2_tick");
         chk(0, 32'h028B, "hold2_q");
      end

      drv(1'b1, 1'b1, 16'h1234, 1'b0);
      chk(0, 32'h1234, "load_q");
      chk(1, 32'd0, "load_ones");
      chk(2, 32'd0, "load_zeros");
      chk(4, 32'd65535, "load_plen");
      chk(3, 32'd0, "load_tick");
      chk(5, 32'd0, "load_lerr");
      drv(1'b1, 1'b0, 16'h0, 1'b0);
      chk(0, 32'h2468, "ld_step1_q");
      chk(2, 32'd1, "ld_step1_zeros");
      drv(1'b1, 1'b0, 16'h0, 1'b0);
      chk(0, 32'h48D0, "ld_step2_q");
      chk(2, 32'd2, "ld_step2_zeros");

      drv(1'b1, 1'b1, 16'hFFFF, 1'b0);
      chk(5, 32'd1, "lock_lerr");
      chk(0, 32'h0145, "lock_q");
      chk(2, 32'd0, "lock_zeros");
      chk(1, 32'd0, "lock_ones");
      chk(4, 32'd65535, "lock_plen");
      chk(3, 32'd0, "lock_tick");
      drv(1'b0, 1'b0, 16'h0, 1'b0);
      chk(5, 32'd0, "lock_lerr_end");
      chk(0, 32'h0145, "lock_hold_q");

      for (int k = 1; k <= 45; k++) begin
         drv(1'b0, 1'b0, 16'h0, 1'b1);
         chk(10, 32'(seq4[(k - 1) % 15]), "w4_q");
         chk(13, 32'((k % 15) == 0), "w4_tick");
         if (k == 15) begin
            chk(14, 32'd15, "w4_plen");
            chk(11, 32'd7, "w4_ones15");
            chk(12, 32'd8, "w4_zeros15");
         end
         if (k == 30) begin
            chk(11, 32'd14, "w4_ones30");
            chk(12, 32'd15, "w4_zeros_sat");
         end
         if (k == 45) begin
            chk(11, 32'd15, "w4_ones_sat");
            chk(12, 32'd15, "w4_zeros45");
            chk(14, 32'd15, "w4_plen45");
         end
      end

      drv(1'b0, 1'b0, 16'h0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         $display("FAIL drain: %0d expectations left, expected 0",
                  sb.size());
         miscompares += sb.size();
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               applied, miscompares);
      $finish;
   end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci XNOR LFSR with run-time seed load, period measurement, output-bit statistics and lock-up protection. It is the general-width successor to the fixed 16-bit LFSR used on the Basys3 board, and feeds the display and statistics logic. It is driven from the board clock with a debounced or divided `sh_en` strobe.

## Interface

- `WIDTH`, 16: LFSR length in bits; legal range 2..32.
- `TAPS`, 16'hD008: feedback mask; bit i set means state bit i enters the XNOR. The default selects bits 15, 14, 12 and 3.
- `SEED`, 16'h0145: state after reset. Must not be all-ones.
- `CNT_W`, 32: width of the statistics and period counters.

- `clk` input, 1: clock, rising edge.
- `reset` input, 1: asynchronous, active-high.
- `sh_en` input, 1: advance one step this cycle.
- `load` input, 1: load `load_val` as the new state and start point.
- `load_val` input, WIDTH: value to load.
- `q` output, WIDTH: current state (registered).
- `ones` output, CNT_W: count of shifted-out bits equal to 1.
- `zeros` output, CNT_W: count of shifted-out bits equal to 0.
- `period_tick` output, 1: one-cycle pulse when the state returns to the start point.
- `period_len` output, CNT_W: step count of the last completed period.
- `lockup_err` output, 1: one-cycle pulse when a rejected all-ones load occurs.

## Operation

- Feedback: `fb = ~^(q & TAPS)`. Next state: `{q[WIDTH-2:0], fb}`. The all-ones state is the lock-up state and is never entered by stepping.
- Internal registers:
  - `start`, WIDTH bits, reset value `SEED`.
  - `step_cnt`, CNT_W bits, reset value 0.
- Reset (async) sets: `q=SEED`, `start=SEED`, `step_cnt=0`, `ones=0`, `zeros=0`, `period_len=0`, `period_tick=0`, `lockup_err=0`.
- Priority per cycle: `load` > `sh_en` > hold.
- Load, with `load_val` not all-ones:
  - `q=load_val`, `start=load_val`.
  - `step_cnt`, `ones` and `zeros` are cleared.
  - `period_len` is kept.
- Load, with `load_val` all-ones:
  - Rejected: `q=SEED`, `start=SEED`, counters cleared as above.
  - `lockup_err=1` for that one cycle.
- Step (`sh_en=1`, `load=0`):
  - `q` takes the next state.
  - The outgoing bit is `q[WIDTH-1]` before the shift. `ones` increments if it is 1; otherwise `zeros` increments.
  - If the next state equals `start`: `period_len=step_cnt+1`, `step_cnt=0`, `period_tick=1`. Otherwise `step_cnt` increments.
- Saturation:
  - `ones`, `zeros` and `step_cnt` saturate at 2^CNT_W-1 and never wrap.
  - A saturated `step_cnt` still latches the saturated value +0 into `period_len`, i.e. all-ones.
- `period_tick` and `lockup_err` are 0 in every cycle not listed above, including hold cycles.
- `start` is never all-ones, so a lock-up can only arise from `SEED` misconfiguration. `SEED` all-ones is an elaboration error.

## Timing

- All outputs are registered, with zero combinational paths from inputs to outputs.
- Step latency: `q` and the counters update on the first rising edge with `sh_en=1`.
- `period_tick` is high in the same cycle that `q==start` first becomes visible after a step.
- `period_tick` is a single-cycle pulse even with continuous `sh_en`.
- `load` and `sh_en` together: the load wins, and no statistics update for that edge.
- Reset mid-period: all outputs take reset values immediately and asynchronously. Stepping resumes on the first edge after deassertion with `sh_en=1`.
- `sh_en` is held high after the period completes: stepping continues, and the next tick arrives exactly `period_len` steps later.

## Test plan

- Reset then hold (`sh_en=0` for 10 cycles) -> `q=16'h0145`, all counters 0, no pulses.
- Defaults, `sh_en=1` for 65535 cycles -> `period_tick` on cycle 65535 only, `period_len=65535`, `ones=32767`, `zeros=32768`, `q=16'h0145`.
- `WIDTH=4`, `TAPS=4'b1100`, `SEED=4'h1`, continuous step -> `period_len=15`, ticks every 15 cycles, all-ones state never seen.
- Load `16'h1234`, step 65535 -> tick exactly when `q==16'h1234`, `period_len=65535`.
- Load `16'hFFFF` with `sh_en=1` -> `lockup_err` pulse, `q=16'h0145`, counters 0, no step that edge.
- Reset asserted mid-period at step 1000 -> immediate reset values. Restarted run gives the first tick after 65535 further steps.
